// File: rtl/rtc_host.sv
// rtl/rtc_host.sv - bus initiator that runs RTC snapshot, control-write and clear sequences
//
// Parameters:
//   MAX_RETRY  re-reads allowed after a high-byte mismatch (0 = none)
//   BASE_ADDR  control register address; timer lo/mid/hi at +1/+2/+3
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   clk_ce              bus-cycle enable; state advances only on enabled edges
//   cmd_valid/ready     command handshake (ready only when idle)
//   cmd_op, cmd_wdata   00 snapshot, 01 write control, 10 clear, 11 reserved
//   rsp_valid/ready     response handshake; exit from response ignores clk_ce
//   rsp_time            {hi,mid,lo} of the last snapshot
//   rsp_enabled         control bit 0 captured by the last snapshot
//   rsp_error           retries exhausted or reserved op
//   bus_address_out     byte address, zero outside bus states
//   bus_data_out        write data, zero outside write states
//   bus_write           write strobe
//   bus_data_in         read data from the addressed peripheral
module rtc_host #(
    parameter int          MAX_RETRY = 3,
    parameter logic [23:0] BASE_ADDR = 24'h2008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [23:0] rsp_time,
    output logic        rsp_enabled,
    output logic        rsp_error,
    output logic [23:0] bus_address_out,
    output logic [7:0]  bus_data_out,
    output logic        bus_write,
    input  logic [7:0]  bus_data_in
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    localparam logic [1:0] OP_SNAP = 2'b00;
    localparam logic [1:0] OP_WCTL = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

    typedef enum logic [3:0] {
        IDLE, RD_CTRL, RD_HI0, RD_MID, RD_LO, RD_HI1,
        WR_A, WR_A_HOLD, WR_B, WR_B_HOLD, RESP
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [1:0]     wdata_q, wdata_d;
    logic           en_q, en_d;
    logic [7:0]     hi0_q, hi0_d;
    logic [7:0]     mid_q, mid_d;
    logic [7:0]     lo_q, lo_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [23:0]    time_q, time_d;
    logic           enabled_q, enabled_d;
    logic           error_q, error_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 2'b00;
            wdata_q   <= 2'b00;
            en_q      <= 1'b0;
            hi0_q     <= 8'd0;
            mid_q     <= 8'd0;
            lo_q      <= 8'd0;
            retry_q   <= '0;
            time_q    <= 24'd0;
            enabled_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wdata_q   <= wdata_d;
            en_q      <= en_d;
            hi0_q     <= hi0_d;
            mid_q     <= mid_d;
            lo_q      <= lo_d;
            retry_q   <= retry_d;
            time_q    <= time_d;
            enabled_q <= enabled_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        wdata_d         = wdata_q;
        en_d            = en_q;
        hi0_d           = hi0_q;
        mid_d           = mid_q;
        lo_d            = lo_q;
        retry_d         = retry_q;
        time_d          = time_q;
        enabled_d       = enabled_q;
        error_d         = error_q;
        bus_address_out = 24'd0;
        bus_data_out    = 8'd0;
        bus_write       = 1'b0;

        case (state_q)
            IDLE: begin
                if (clk_ce && cmd_valid) begin
                    op_d    = cmd_op;
                    wdata_d = cmd_wdata;
                    error_d = 1'b0;
                    retry_d = '0;
                    case (cmd_op)
                        OP_SNAP: state_d = RD_CTRL;
                        OP_WCTL,
                        OP_CLR:  state_d = WR_A;
                        default: begin
                            error_d = 1'b1;
                            state_d = RESP;
                        end
                    endcase
                end
            end
            RD_CTRL: begin
                bus_address_out = BASE_ADDR;
                if (clk_ce) begin
                    en_d    = bus_data_in[0];
                    state_d = RD_HI0;
                end
            end
            RD_HI0: begin
                bus_address_out = BASE_ADDR + 24'd3;
                if (clk_ce) begin
                    hi0_d   = bus_data_in;
                    state_d = RD_MID;
                end
            end
            RD_MID: begin
                bus_address_out = BASE_ADDR + 24'd2;
                if (clk_ce) begin
                    mid_d   = bus_data_in;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                bus_address_out = BASE_ADDR + 24'd1;
                if (clk_ce) begin
                    lo_d    = bus_data_in;
                    state_d = RD_HI1;
                end
            end
            RD_HI1: begin
                bus_address_out = BASE_ADDR + 24'd3;
                if (clk_ce) begin
                    // A changed high byte means mid/lo may belong to either side
                    // of a carry; re-read them against the new high byte.
                    if (bus_data_in != hi0_q && retry_q < RETRY_LIM) begin
                        hi0_d   = bus_data_in;
                        retry_d = retry_q + RW'(1);
                        state_d = RD_MID;
                    end else begin
                        error_d   = (bus_data_in != hi0_q);
                        time_d    = {bus_data_in, mid_q, lo_q};
                        enabled_d = en_q;
                        state_d   = RESP;
                    end
                end
            end
            WR_A, WR_A_HOLD: begin
                bus_address_out = BASE_ADDR;
                bus_data_out    = (op_q == OP_CLR) ? {6'd0, 1'b1, wdata_q[0]} : {6'd0, wdata_q};
                bus_write       = (state_q == WR_A);
                if (clk_ce) begin
                    if (state_q == WR_A)
                        state_d = WR_A_HOLD;
                    else
                        state_d = (op_q == OP_CLR) ? WR_B : RESP;
                end
            end
            WR_B, WR_B_HOLD: begin
                // Second write drops the timer reset bit so it restarts from 0.
                bus_address_out = BASE_ADDR;
                bus_data_out    = {6'd0, 1'b0, wdata_q[0]};
                bus_write       = (state_q == WR_B);
                if (clk_ce)
                    state_d = (state_q == WR_B) ? WR_B_HOLD : RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_time    = time_q;
    assign rsp_enabled = enabled_q;
    assign rsp_error   = error_q;

endmodule

// File: tb/tb_rtc_host.sv
// tb/tb_rtc_host.sv - scoreboard bench for rtc_host with a behavioural RTC register model
module tb_rtc_host;

    logic        clk = 1'b0;
    logic        reset, clk_ce, cmd_valid, cmd_valid0, rsp_ready;
    logic [1:0]  cmd_op, cmd_wdata;
    logic        cmd_ready, rsp_valid, rsp_enabled, rsp_error, bus_write;
    logic [23:0] rsp_time, bus_address_out;
    logic [7:0]  bus_data_out, bus_data_in;
    logic        cmd_ready0, rsp_valid0, rsp_enabled0, rsp_error0, bus_write0;
    logic [23:0] rsp_time0, bus_address_out0;
    logic [7:0]  bus_data_out0, bus_data_in0;

    always #5 clk = ~clk;

    rtc_host u_dut (
        .clk(clk), .reset(reset), .clk_ce(clk_ce),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_time(rsp_time),
        .rsp_enabled(rsp_enabled), .rsp_error(rsp_error),
        .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
        .bus_write(bus_write), .bus_data_in(bus_data_in)
    );

    rtc_host #(.MAX_RETRY(0)) u_dut0 (
        .clk(clk), .reset(reset), .clk_ce(clk_ce),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_time(rsp_time0),
        .rsp_enabled(rsp_enabled0), .rsp_error(rsp_error0),
        .bus_address_out(bus_address_out0), .bus_data_out(bus_data_out0),
        .bus_write(bus_write0), .bus_data_in(bus_data_in0)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RTC register model: mode 0 static hi, 1 hi bumps once after first read, 2 hi bumps every read
    logic [7:0] hi_v = 8'h00, mid_v = 8'h00, lo_v = 8'h00;
    int         mode = 0;
    logic       ctrl_m = 1'b1, cleared_m = 1'b0;
    logic [7:0] hi_reads = 8'd0, hi_rd0 = 8'd0, hi_reads0 = 8'd0;
    logic [7:0] off, hi_cur;

    assign off    = hi_reads - hi_rd0;
    assign hi_cur = (mode == 0) ? hi_v : (mode == 1) ? hi_v + {7'd0, off != 8'd0} : hi_v + off;

    always_comb begin
        bus_data_in = 8'h00;
        case (bus_address_out)
            24'h2008: bus_data_in = {7'd0, ctrl_m};
            24'h2009: bus_data_in = cleared_m ? 8'h00 : lo_v;
            24'h200A: bus_data_in = cleared_m ? 8'h00 : mid_v;
            24'h200B: bus_data_in = cleared_m ? 8'h00 : hi_cur;
            default:  bus_data_in = 8'h00;
        endcase
    end

    assign bus_data_in0 = (bus_address_out0 == 24'h200B) ? hi_v + hi_reads0 :
                          (bus_address_out0 == 24'h200A) ? mid_v :
                          (bus_address_out0 == 24'h2009) ? lo_v :
                          (bus_address_out0 == 24'h2008) ? 8'h01 : 8'h00;

    always @(posedge clk) begin
        if (!reset && clk_ce) begin
            if (bus_address_out == 24'h200B && !bus_write) hi_reads <= hi_reads + 8'd1;
            if (bus_address_out0 == 24'h200B) hi_reads0 <= hi_reads0 + 8'd1;
            if (bus_write && bus_address_out == 24'h2008) begin
                ctrl_m <= bus_data_out[0];
                if (bus_data_out[1]) cleared_m <= 1'b1;
            end
        end
    end

    // clock enable: every clock, or one clock in three
    int ce_mode = 0;
    int ce_cnt  = 0;
    initial begin
        clk_ce = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ce_cnt++;
            clk_ce = (ce_mode == 0) || (ce_cnt % 3 == 0);
        end
    end

    // bus / busy monitor
    logic [32:0] bus_log[$];
    logic [32:0] exp_bus[$];
    int ce_busy  = 0;
    int clk_busy = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (clk_ce && bus_address_out != 24'd0)
                bus_log.push_back({bus_address_out, bus_write, bus_data_out});
            if (!cmd_ready && !rsp_valid) begin
                clk_busy++;
                if (clk_ce) ce_busy++;
            end
        end
    end

    // response scoreboard
    typedef struct packed {
        logic [23:0] t;
        logic        en;
        logic        err;
    } rsp_t;
    rsp_t sb[$];
    rsp_t exp_r;
    int   n_rsp = 0;
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_r = sb.pop_front();
                check("rsp_time", {40'd0, rsp_time}, {40'd0, exp_r.t});
                check("rsp_enabled", {63'd0, rsp_enabled}, {63'd0, exp_r.en});
                check("rsp_error", {63'd0, rsp_error}, {63'd0, exp_r.err});
            end
        end
    end

    task automatic exp_snap(input int retries);
        exp_bus.push_back({24'h2008, 9'd0});
        exp_bus.push_back({24'h200B, 9'd0});
        exp_bus.push_back({24'h200A, 9'd0});
        exp_bus.push_back({24'h2009, 9'd0});
        exp_bus.push_back({24'h200B, 9'd0});
        for (int r = 0; r < retries; r++) begin
            exp_bus.push_back({24'h200A, 9'd0});
            exp_bus.push_back({24'h2009, 9'd0});
            exp_bus.push_back({24'h200B, 9'd0});
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [1:0] wd, input logic [23:0] et,
                          input logic ee, input logic er, input int elat, input int hold);
        int  b0, c0, held, n;
        bit  ok;
        sb.push_back({et, ee, er});
        b0     = bus_log.size();
        c0     = ce_busy;
        hi_rd0 = hi_reads;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (clk_ce && cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", {63'd0, ok}, 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("rsp_seen", {63'd0, ok}, 64'd1);
        check("latency", 64'(ce_busy - c0), 64'(elat));
        held = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid && !cmd_ready) held++;
        end
        if (hold > 0) check("rsp_held", 64'(held), 64'(hold));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n = exp_bus.size();
        check("bus_count", 64'(bus_log.size() - b0), 64'(n));
        for (int i = 0; i < n; i++)
            if (b0 + i < bus_log.size())
                check($sformatf("bus%0d", i), {31'd0, bus_log[b0 + i]}, {31'd0, exp_bus[i]});
        exp_bus.delete();
    endtask

    bit ok;
    int n, ck0, quiet;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_valid0 = 1'b0; rsp_ready = 1'b0;
        cmd_op = 2'b00; cmd_wdata = 2'b00;
        hi_v = 8'h12; mid_v = 8'h34; lo_v = 8'h56; mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_time", {40'd0, rsp_time}, 64'd0);
        check("rst_bus_addr", {40'd0, bus_address_out}, 64'd0);
        check("rst_bus_write", {63'd0, bus_write}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // static snapshot
        exp_snap(0);
        do_cmd(2'b00, 2'b00, 24'h123456, 1'b1, 1'b0, 5, 0);

        // hi byte carries once between reads: one retry
        mode = 1; hi_v = 8'h12; mid_v = 8'h00; lo_v = 8'h01;
        exp_snap(1);
        do_cmd(2'b00, 2'b00, 24'h130001, 1'b1, 1'b0, 8, 0);

        // hi byte changes on every read: retries exhausted
        mode = 2; hi_v = 8'h20; mid_v = 8'h44; lo_v = 8'h55;
        exp_snap(3);
        do_cmd(2'b00, 2'b00, 24'h244455, 1'b1, 1'b1, 14, 0);

        // MAX_RETRY=0 instance: error after the first mismatch
        @(posedge clk);
        #1;
        cmd_valid0 = 1'b1; cmd_op = 2'b00;
        @(posedge clk);
        #1;
        cmd_valid0 = 1'b0;
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid0) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        check("r0_seen", {63'd0, ok}, 64'd1);
        check("r0_latency", 64'(n), 64'd5);
        check("r0_error", {63'd0, rsp_error0}, 64'd1);
        check("r0_time", {40'd0, rsp_time0}, 64'h214455);
        check("r0_enabled", {63'd0, rsp_enabled0}, 64'd1);
        check("r0_no_write", {55'd0, bus_write0, bus_data_out0}, 64'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("r0_released", {62'd0, rsp_valid0, cmd_ready0}, 64'd1);

        // write control with enable cleared; snapshot fields hold
        exp_bus.push_back({24'h2008, 1'b1, 8'h00});
        exp_bus.push_back({24'h2008, 1'b0, 8'h00});
        do_cmd(2'b01, 2'b00, 24'h244455, 1'b1, 1'b0, 2, 0);

        // reserved op
        do_cmd(2'b11, 2'b00, 24'h244455, 1'b1, 1'b1, 0, 0);

        // clk_ce one-in-three, response withheld 10 clocks
        mode = 0; hi_v = 8'hAB; mid_v = 8'hCD; lo_v = 8'hEF;
        ce_mode = 1;
        ck0 = clk_busy;
        exp_snap(0);
        do_cmd(2'b00, 2'b00, 24'hABCDEF, 1'b0, 1'b0, 5, 10);
        check("stretch_clocks", 64'(clk_busy - ck0), 64'd15);
        ce_mode = 0;

        // reset during RD_MID abandons the snapshot
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_op = 2'b00;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_address_out == 24'h200A) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_mid", {63'd0, ok}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_ready", {63'd0, cmd_ready}, 64'd1);
        check("mrst_outs", {29'd0, rsp_valid, rsp_error, rsp_enabled, rsp_time, bus_address_out},
              64'd0);
        check("mrst_bus", {55'd0, bus_write, bus_data_out}, 64'd0);
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid && bus_address_out == 24'd0) quiet++;
        end
        check("mrst_quiet", 64'(quiet), 64'd10);
        hi_v = 8'h01; mid_v = 8'h02; lo_v = 8'h03;
        exp_snap(0);
        do_cmd(2'b00, 2'b00, 24'h010203, 1'b0, 1'b0, 5, 0);

        // clear with enable, then snapshot of the restarted timer
        exp_bus.push_back({24'h2008, 1'b1, 8'h03});
        exp_bus.push_back({24'h2008, 1'b0, 8'h03});
        exp_bus.push_back({24'h2008, 1'b1, 8'h01});
        exp_bus.push_back({24'h2008, 1'b0, 8'h01});
        do_cmd(2'b10, 2'b01, 24'h010203, 1'b0, 1'b0, 4, 0);
        exp_snap(0);
        do_cmd(2'b00, 2'b00, 24'h000000, 1'b1, 1'b0, 5, 0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        check("rsp_count", 64'(n_rsp), 64'd9);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
